rast_hit_merge: RTL and testbench

N-lane hit merger placed at the output of `rast`, after the sample stage. It replaces the fixed dual-lane output (`hit_R18S` and `hit_R18S_2`) with a single valid/ready stream. Each of `LANES` hit lanes is buffered in its own FIFO and drained through a fair round-robin arbiter. Backpressure is returned upstream as `halt_RnnnnL`, and a sticky overflow flag is raised if any hit is lost.

---
 rtl/rast_params.sv | 13 +
 rtl/hit_fifo.sv | 38 +++
 rtl/rast_hit_merge.sv | 87 ++++++++
 tb/tb_rast_hit_merge.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rast_params.sv
// rast_params: shared constants and hit record for the rast output stage
package rast_params;
    localparam int SIGFIG      = 24;
    localparam int AXIS        = 3;
    localparam int COLORS      = 3;
    localparam int LANES       = 2;
    localparam int MERGE_DEPTH = 4;
    localparam int HALT_MARGIN = 2;
    typedef struct packed {
        logic [AXIS-1:0][SIGFIG-1:0]   hit;
        logic [COLORS-1:0][SIGFIG-1:0] color;
    } hit_t;
endpackage

// File: rtl/hit_fifo.sv
// hit_fifo: single-lane hit buffer with registered storage and push+pop when full
module hit_fifo
    import rast_params::*;
#(
    parameter int  DEPTH = MERGE_DEPTH,
    parameter type T     = hit_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  T            din,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output T            head
);
    T mem [DEPTH];
    logic [AW-1:0] rd, wr;
    // storage carries no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) if (push) mem[wr] <= din;
    // pointers wrap modulo DEPTH; the caller only pushes when not full or popping
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            rd    <= rd + AW'(pop);
            wr    <= wr + AW'(push);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head  = mem[rd];
endmodule

// File: rtl/rast_hit_merge.sv
// rast_hit_merge: merges per-lane hit FIFOs into one valid/ready stream, round-robin
module rast_hit_merge
    import rast_params::hit_t;
#(
    parameter int  LANES       = rast_params::LANES,
    parameter int  DEPTH       = rast_params::MERGE_DEPTH,
    parameter int  HALT_MARGIN = rast_params::HALT_MARGIN,
    localparam int LW          = LANES > 1 ? $clog2(LANES) : 1,
    localparam int CW          = $clog2(DEPTH) + 1,
    localparam int SF          = rast_params::SIGFIG,
    localparam int AX          = rast_params::AXIS,
    localparam int CO          = rast_params::COLORS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic signed [LANES-1:0][AX-1:0][SF-1:0] hit_in_S,
    input  logic [LANES-1:0][CO-1:0][SF-1:0]        color_in_U,
    input  logic [LANES-1:0]                        hit_valid_in_H,
    output logic                                   halt_RnnnnL,
    output logic signed [AX-1:0][SF-1:0]            hit_out_S,
    output logic [CO-1:0][SF-1:0]                   color_out_U,
    output logic [LW-1:0]                           lane_out_U,
    output logic                                   hit_valid_out_H,
    input  logic                                   hit_ready_in_H,
    output logic                                   overflow_H
);
    logic [LANES-1:0]          push, pop, full, empty;
    logic [LANES-1:0][CW-1:0]  count;
    hit_t [LANES-1:0]          head;
    logic [LW-1:0]             rr_ptr, gnt, gnt_q, scan;
    logic                      lock, xfer, halt_n;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        hit_fifo #(.DEPTH(DEPTH), .T(hit_t)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   ({hit_in_S[i], color_in_U[i]}),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count[i]),
            .head  (head[i])
        );
    end

    // first non-empty lane at or after rr_ptr: lowest overall, overridden by lowest >= rr_ptr
    always_comb begin
        scan = '0;
        for (int k = LANES - 1; k >= 0; k--) if (!empty[k]) scan = LW'(k);
        for (int k = LANES - 1; k >= 0; k--) if (!empty[k] && LW'(k) >= rr_ptr) scan = LW'(k);
    end

    assign gnt             = lock ? gnt_q : scan;
    assign hit_valid_out_H = |(~empty);
    assign xfer            = hit_valid_out_H && hit_ready_in_H;
    assign push            = hit_valid_in_H & (~full | pop);
    assign hit_out_S       = hit_valid_out_H ? head[gnt].hit : '0;
    assign color_out_U     = hit_valid_out_H ? head[gnt].color : '0;
    assign lane_out_U      = hit_valid_out_H ? gnt : '0;

    // pop the granted lane and look ahead at every lane's next occupancy for halt
    always_comb begin
        pop    = '0;
        halt_n = 1'b1;
        if (xfer) pop[gnt] = 1'b1;
        for (int k = 0; k < LANES; k++)
            if (count[k] + CW'(push[k]) - CW'(pop[k]) >= CW'(DEPTH - HALT_MARGIN)) halt_n = 1'b0;
    end

    // lock holds the grant through a stall; rr_ptr advances past each served lane
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr      <= '0;
            gnt_q       <= '0;
            lock        <= 1'b0;
            halt_RnnnnL <= 1'b1;
            overflow_H  <= 1'b0;
        end else begin
            lock        <= hit_valid_out_H && !hit_ready_in_H;
            gnt_q       <= gnt;
            halt_RnnnnL <= halt_n;
            overflow_H  <= overflow_H | (|(hit_valid_in_H & full & ~pop));
            if (xfer) rr_ptr <= gnt == LW'(LANES - 1) ? '0 : gnt + LW'(1);
        end
    end
endmodule

// File: tb/tb_rast_hit_merge.sv
// tb_rast_hit_merge: directed table plus randomized run against a queue-based model
module tb_rast_hit_merge;
    import rast_params::*;
    localparam int L = 2, D = 4, M = 2;

    logic clk = 1'b0, rst = 1'b0;
    logic [L-1:0][AXIS-1:0][SIGFIG-1:0]   hit_in_S;
    logic [L-1:0][COLORS-1:0][SIGFIG-1:0] color_in_U;
    logic [L-1:0]                         hit_valid_in_H;
    logic                                 halt_RnnnnL, hit_valid_out_H, hit_ready_in_H, overflow_H;
    logic [AXIS-1:0][SIGFIG-1:0]          hit_out_S;
    logic [COLORS-1:0][SIGFIG-1:0]        color_out_U;
    logic [0:0]                           lane_out_U;

    always #5 clk = ~clk;

    rast_hit_merge #(.LANES(L), .DEPTH(D), .HALT_MARGIN(M)) dut (
        .clk            (clk),
        .rst            (rst),
        .hit_in_S       (hit_in_S),
        .color_in_U     (color_in_U),
        .hit_valid_in_H (hit_valid_in_H),
        .halt_RnnnnL    (halt_RnnnnL),
        .hit_out_S      (hit_out_S),
        .color_out_U    (color_out_U),
        .lane_out_U     (lane_out_U),
        .hit_valid_out_H(hit_valid_out_H),
        .hit_ready_in_H (hit_ready_in_H),
        .overflow_H     (overflow_H)
    );

    typedef struct packed {
        logic        r;
        logic [1:0]  v;
        logic        rd;
        logic [23:0] t0, t1;
        logic        c, ev, el;
        logic [23:0] ed;
        logic        eh, eo;
    } vec_t;

    vec_t tv[$];
    hit_t mq [L][$];
    int   m_rr, m_lg, checks, errors, cur_row;
    bit   m_lock, m_halt, m_ovf, m_ok;

    function automatic hit_t mk(input logic [23:0] tag);
        hit_t h;
        for (int k = 0; k < AXIS; k++) h.hit[k] = tag + 24'(k);
        for (int k = 0; k < COLORS; k++) h.color[k] = tag ^ (24'hA50000 + 24'(k));
        return h;
    endfunction

    function automatic void add(input logic r, input logic [1:0] v, input logic rd, input int t0, input int t1,
                                input logic c, input logic ev, input logic el, input int ed, input logic eh, input logic eo);
        tv.push_back('{r, v, rd, 24'(t0), 24'(t1), c, ev, el, 24'(ed), eh, eo});
    endfunction

    function automatic int m_gnt();
        if (m_lock) return m_lg;
        for (int k = 0; k < L; k++) if (mq[(m_rr + k) % L].size() != 0) return (m_rr + k) % L;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, cur_row, got, exp);
        end
    endtask

    task automatic step(input vec_t x);
        hit_t d0, d1, e;
        bit   mv;
        int   g;
        d0 = mk(x.t0);
        d1 = mk(x.t1);
        rst = x.r;
        hit_valid_in_H = x.v;
        hit_ready_in_H = x.rd;
        hit_in_S[0] = d0.hit;
        color_in_U[0] = d0.color;
        hit_in_S[1] = d1.hit;
        color_in_U[1] = d1.color;
        @(negedge clk);
        mv = 0;
        for (int k = 0; k < L; k++) if (mq[k].size() != 0) mv = 1;
        g = mv ? m_gnt() : 0;
        e = mv ? mq[g][0] : '0;
        if (m_ok) begin
            chk("model valid", hit_valid_out_H, mv);
            chk("model lane", lane_out_U, g);
            chk("model data", {hit_out_S, color_out_U}, e);
            chk("model halt", halt_RnnnnL, m_halt);
            chk("model overflow", overflow_H, m_ovf);
        end
        if (x.c) begin
            chk("table valid", hit_valid_out_H, x.ev);
            chk("table lane", lane_out_U, x.el);
            chk("table data", hit_out_S[0], x.ed);
            chk("table halt", halt_RnnnnL, x.eh);
            chk("table overflow", overflow_H, x.eo);
        end
        if (!x.r) begin
            for (int k = 0; k < L; k++) mq[k].delete();
            m_rr = 0; m_lg = 0; m_lock = 0; m_halt = 1; m_ovf = 0; m_ok = 1;
        end else begin
            if (mv && x.rd) begin
                void'(mq[g].pop_front());
                m_rr = (g + 1) % L;
            end
            m_lock = mv && !x.rd;
            m_lg = g;
            if (x.v[0]) begin if (mq[0].size() < D) mq[0].push_back(d0); else m_ovf = 1; end
            if (x.v[1]) begin if (mq[1].size() < D) mq[1].push_back(d1); else m_ovf = 1; end
            m_halt = 1;
            for (int k = 0; k < L; k++) if (mq[k].size() >= D - M) m_halt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0;
        // reset and single hit
        add(0,0,1,0,0,    0, 0,0,0,1,0);
        add(1,0,1,0,0,    1, 0,0,0,1,0);
        add(1,1,1,1,0,    1, 0,0,0,1,0);
        add(1,0,1,0,0,    1, 1,0,1,1,0);
        add(1,0,1,0,0,    1, 0,0,0,1,0);
        add(0,0,1,0,0,    1, 0,0,0,1,0);
        add(1,0,1,0,0,    1, 0,0,0,1,0);
        // fairness: both lanes valid four cycles
        add(1,3,1,10,110, 1, 0,0,0,1,0);
        add(1,3,1,11,111, 1, 1,0,10,1,0);
        add(1,3,1,12,112, 1, 1,1,110,0,0);
        add(1,3,1,13,113, 1, 1,0,11,0,0);
        add(1,0,1,0,0,    1, 1,1,111,0,0);
        add(1,0,1,0,0,    1, 1,0,12,0,0);
        add(1,0,1,0,0,    1, 1,1,112,0,0);
        add(1,0,1,0,0,    1, 1,0,13,1,0);
        add(1,0,1,0,0,    1, 1,1,113,1,0);
        add(1,0,1,0,0,    1, 0,0,0,1,0);
        // stall/lock: lane 1 held while lane 0 arrives
        add(1,2,0,0,200,  1, 0,0,0,1,0);
        add(1,1,0,20,0,   1, 1,1,200,1,0);
        add(1,0,0,0,0,    1, 1,1,200,1,0);
        add(1,0,1,0,0,    1, 1,1,200,1,0);
        add(1,0,1,0,0,    1, 1,0,20,1,0);
        add(1,0,1,0,0,    1, 0,0,0,1,0);
        // halt, full push+pop, overflow
        add(1,1,0,30,0,   1, 0,0,0,1,0);
        add(1,1,0,31,0,   1, 1,0,30,1,0);
        add(1,1,0,32,0,   1, 1,0,30,0,0);
        add(1,1,0,33,0,   1, 1,0,30,0,0);
        add(1,1,1,34,0,   1, 1,0,30,0,0);
        add(1,1,0,35,0,   1, 1,0,31,0,0);
        add(1,0,1,0,0,    1, 1,0,31,0,1);
        add(1,0,1,0,0,    1, 1,0,32,0,1);
        add(1,0,1,0,0,    1, 1,0,33,0,1);
        add(1,0,1,0,0,    1, 1,0,34,1,1);
        add(1,0,1,0,0,    1, 0,0,0,1,1);
        // reset mid-stream
        add(1,3,0,40,140, 1, 0,0,0,1,1);
        add(0,0,0,0,0,    1, 1,1,140,1,1);
        add(1,0,1,0,0,    1, 0,0,0,1,0);
        add(1,0,1,0,0,    1, 0,0,0,1,0);
        foreach (tv[i]) begin
            cur_row = i;
            step(tv[i]);
        end
        for (int n = 0; n < 3000; n++) begin
            vec_t x;
            int   pr;
            pr = ((n / 500) % 2 == 1) ? 90 : 35;
            x = '{($urandom_range(199) != 0), 2'($urandom), ($urandom_range(99) < pr),
                  24'($urandom), 24'($urandom), 1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0};
            cur_row = 1000 + n;
            step(x);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
